// File: rtl/axi_addr_router.sv
// axi_addr_router
//   Routes one upstream AXI-style master to N_SLAVES downstream slaves by
//   address window. Each slave owns the window whose upper address bits match
//   its base, where the window size is 2**SLV_SIZE_LOG2 bytes. If windows
//   overlap, the lowest slave index wins. An address that matches no window is
//   answered locally with a decode error (DECERR).
//   Write and read paths are independent. Each path allows one transaction in
//   flight at a time.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   s_aw*/s_w*/s_b* upstream write address, data and response channels
//   s_ar*/s_r*      upstream read address and data channels
//   m_*             downstream channels with one slice per slave. Payload
//                   fields are broadcast to every slave; only valid/ready are
//                   steered to the selected slave.
module axi_addr_router #(
  parameter int N_SLAVES   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h1000_0000, 32'hFEED_0000},
  parameter logic [N_SLAVES*6-1:0]          SLV_SIZE_LOG2 = {6'd16, 6'd12}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // upstream write address
  input  logic [7:0]                     s_awid,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [7:0]                     s_awln,
  input  logic [1:0]                     s_awsize,
  input  logic [1:0]                     s_awburst,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  // upstream write data
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wlast,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  // upstream write response
  output logic [7:0]                     s_bid,
  output logic                           s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  // upstream read address
  input  logic [7:0]                     s_arid,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [7:0]                     s_arln,
  input  logic [1:0]                     s_arsize,
  input  logic [1:0]                     s_arburst,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  // upstream read data
  output logic [7:0]                     s_rid,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic                           s_rresp,
  output logic                           s_rlast,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  // downstream write address
  output logic [N_SLAVES*8-1:0]          m_awid,
  output logic [N_SLAVES*ADDR_WIDTH-1:0] m_awaddr,
  output logic [N_SLAVES*8-1:0]          m_awln,
  output logic [N_SLAVES*2-1:0]          m_awsize,
  output logic [N_SLAVES*2-1:0]          m_awburst,
  output logic [N_SLAVES-1:0]            m_awvalid,
  input  logic [N_SLAVES-1:0]            m_awready,
  // downstream write data
  output logic [N_SLAVES*DATA_WIDTH-1:0] m_wdata,
  output logic [N_SLAVES*DATA_WIDTH/8-1:0] m_wstrb,
  output logic [N_SLAVES-1:0]            m_wlast,
  output logic [N_SLAVES-1:0]            m_wvalid,
  input  logic [N_SLAVES-1:0]            m_wready,
  // downstream write response
  input  logic [N_SLAVES*8-1:0]          m_bid,
  input  logic [N_SLAVES-1:0]            m_bresp,
  input  logic [N_SLAVES-1:0]            m_bvalid,
  output logic [N_SLAVES-1:0]            m_bready,
  // downstream read address
  output logic [N_SLAVES*8-1:0]          m_arid,
  output logic [N_SLAVES*ADDR_WIDTH-1:0] m_araddr,
  output logic [N_SLAVES*8-1:0]          m_arln,
  output logic [N_SLAVES*2-1:0]          m_arsize,
  output logic [N_SLAVES*2-1:0]          m_arburst,
  output logic [N_SLAVES-1:0]            m_arvalid,
  input  logic [N_SLAVES-1:0]            m_arready,
  // downstream read data
  input  logic [N_SLAVES*8-1:0]          m_rid,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] m_rdata,
  input  logic [N_SLAVES-1:0]            m_rresp,
  input  logic [N_SLAVES-1:0]            m_rlast,
  input  logic [N_SLAVES-1:0]            m_rvalid,
  output logic [N_SLAVES-1:0]            m_rready
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Address decode and payload broadcast
  logic [N_SLAVES-1:0] aw_hit, ar_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      localparam logic [5:0]            SZ   = SLV_SIZE_LOG2[gi*6 +: 6];
      localparam logic [ADDR_WIDTH-1:0] BASE = SLV_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];

      assign aw_hit[gi] = ((s_awaddr >> SZ) == (BASE >> SZ));
      assign ar_hit[gi] = ((s_araddr >> SZ) == (BASE >> SZ));

      assign m_awid   [gi*8 +: 8]                   = s_awid;
      assign m_awaddr [gi*ADDR_WIDTH +: ADDR_WIDTH] = s_awaddr;
      assign m_awln   [gi*8 +: 8]                   = s_awln;
      assign m_awsize [gi*2 +: 2]                   = s_awsize;
      assign m_awburst[gi*2 +: 2]                   = s_awburst;
      assign m_wdata  [gi*DATA_WIDTH +: DATA_WIDTH] = s_wdata;
      assign m_wstrb  [gi*SW +: SW]                 = s_wstrb;
      assign m_wlast  [gi]                          = s_wlast;
      assign m_arid   [gi*8 +: 8]                   = s_arid;
      assign m_araddr [gi*ADDR_WIDTH +: ADDR_WIDTH] = s_araddr;
      assign m_arln   [gi*8 +: 8]                   = s_arln;
      assign m_arsize [gi*2 +: 2]                   = s_arsize;
      assign m_arburst[gi*2 +: 2]                   = s_arburst;
    end
  endgenerate

  // Priority encoder: the lowest hit index wins.
  function automatic logic [SEL_W-1:0] first_hit(input logic [N_SLAVES-1:0] hit);
    first_hit = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) first_hit = SEL_W'(i);
    end
  endfunction

  logic [SEL_W-1:0] aw_sel, ar_sel;
  logic             aw_any, ar_any;

  assign aw_sel = first_hit(aw_hit);
  assign ar_sel = first_hit(ar_hit);
  assign aw_any = |aw_hit;
  assign ar_any = |ar_hit;

  // Write path
  w_state_t         w_state_reg, w_state_next;
  logic [SEL_W-1:0] w_sel_reg, w_sel_next;
  logic             w_decerr_reg, w_decerr_next;
  logic [7:0]       awid_reg, awid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg  <= W_IDLE;
      w_sel_reg    <= '0;
      w_decerr_reg <= 1'b0;
      awid_reg     <= '0;
    end else begin
      w_state_reg  <= w_state_next;
      w_sel_reg    <= w_sel_next;
      w_decerr_reg <= w_decerr_next;
      awid_reg     <= awid_next;
    end
  end

  always_comb begin
    w_state_next  = w_state_reg;
    w_sel_next    = w_sel_reg;
    w_decerr_next = w_decerr_reg;
    awid_next     = awid_reg;
    m_awvalid     = '0;
    m_wvalid      = '0;
    m_bready      = '0;
    s_awready     = 1'b0;
    s_wready      = 1'b0;
    s_bvalid      = 1'b0;
    s_bid         = m_bid[w_sel_reg*8 +: 8];
    s_bresp       = m_bresp[w_sel_reg];

    case (w_state_reg)
      W_IDLE: begin
        // W is never accepted here, even when it arrives together with AW.
        if (aw_any) begin
          m_awvalid[aw_sel] = s_awvalid;
          s_awready         = m_awready[aw_sel];
        end else begin
          s_awready = 1'b1;
        end
        if (s_awvalid && s_awready) begin
          w_sel_next    = aw_sel;
          w_decerr_next = !aw_any;
          awid_next     = s_awid;
          w_state_next  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_decerr_reg) begin
          s_wready = 1'b1;  // sink and discard the data
        end else begin
          m_wvalid[w_sel_reg] = s_wvalid;
          s_wready            = m_wready[w_sel_reg];
        end
        if (s_wvalid && s_wready && s_wlast) w_state_next = W_RESP;
      end
      W_RESP: begin
        if (w_decerr_reg) begin
          s_bvalid = 1'b1;
          s_bid    = awid_reg;
          s_bresp  = 1'b1;
        end else begin
          s_bvalid            = m_bvalid[w_sel_reg];
          m_bready[w_sel_reg] = s_bready;
        end
        if (s_bvalid && s_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase

    // While reset is asserted, every handshake signal is held low.
    if (!rst_n) begin
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
    end
  end

  // Read path
  r_state_t         r_state_reg, r_state_next;
  logic [SEL_W-1:0] r_sel_reg, r_sel_next;
  logic             r_decerr_reg, r_decerr_next;
  logic [7:0]       arid_reg, arid_next;
  logic [7:0]       arln_reg, arln_next;
  logic [7:0]       beat_cnt_reg, beat_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg  <= R_IDLE;
      r_sel_reg    <= '0;
      r_decerr_reg <= 1'b0;
      arid_reg     <= '0;
      arln_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      r_state_reg  <= r_state_next;
      r_sel_reg    <= r_sel_next;
      r_decerr_reg <= r_decerr_next;
      arid_reg     <= arid_next;
      arln_reg     <= arln_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    r_state_next  = r_state_reg;
    r_sel_next    = r_sel_reg;
    r_decerr_next = r_decerr_reg;
    arid_next     = arid_reg;
    arln_next     = arln_reg;
    beat_cnt_next = beat_cnt_reg;
    m_arvalid     = '0;
    m_rready      = '0;
    s_arready     = 1'b0;
    s_rvalid      = 1'b0;
    s_rid         = m_rid[r_sel_reg*8 +: 8];
    s_rdata       = m_rdata[r_sel_reg*DATA_WIDTH +: DATA_WIDTH];
    s_rresp       = m_rresp[r_sel_reg];
    s_rlast       = m_rlast[r_sel_reg];

    case (r_state_reg)
      R_IDLE: begin
        if (ar_any) begin
          m_arvalid[ar_sel] = s_arvalid;
          s_arready         = m_arready[ar_sel];
        end else begin
          s_arready = 1'b1;
        end
        if (s_arvalid && s_arready) begin
          r_sel_next    = ar_sel;
          r_decerr_next = !ar_any;
          arid_next     = s_arid;
          arln_next     = s_arln;
          beat_cnt_next = '0;
          r_state_next  = R_DATA;
        end
      end
      R_DATA: begin
        if (r_decerr_reg) begin
          // Generate arln+1 error beats locally.
          s_rvalid = 1'b1;
          s_rid    = arid_reg;
          s_rdata  = '0;
          s_rresp  = 1'b1;
          s_rlast  = (beat_cnt_reg == arln_reg);
          if (s_rready) begin
            if (s_rlast) r_state_next = R_IDLE;
            else         beat_cnt_next = beat_cnt_reg + 8'd1;
          end
        end else begin
          s_rvalid            = m_rvalid[r_sel_reg];
          m_rready[r_sel_reg] = s_rready;
          if (s_rvalid && s_rready && s_rlast) r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase

    if (!rst_n) begin
      m_arvalid = '0;
      m_rready  = '0;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_addr_router.sv
// Testbench for axi_addr_router with the default two-slave map:
//   slave 0 = 0xFEED_0000, 4 KiB window
//   slave 1 = 0x1000_0000, 64 KiB window
// The bench plays both the upstream master and the downstream slaves.
// Each task pushes the upstream responses it expects into exp_q. A separate
// monitor process pops from exp_q and compares on every upstream B or R
// handshake.
module tb_axi_addr_router;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] s_awid, s_awln, s_arid, s_arln, s_bid, s_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [1:0] s_awsize, s_awburst, s_arsize, s_arburst;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic s_bresp, s_bvalid, s_bready, s_arvalid, s_arready;
  logic s_rresp, s_rlast, s_rvalid, s_rready;
  logic [N*8-1:0] m_awid, m_awln, m_bid, m_arid, m_arln, m_rid;
  logic [N*AW-1:0] m_awaddr, m_araddr;
  logic [N*2-1:0] m_awsize, m_awburst, m_arsize, m_arburst;
  logic [N-1:0] m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [N*DW-1:0] m_wdata, m_rdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N-1:0] m_bresp, m_bvalid, m_bready, m_arvalid, m_arready;
  logic [N-1:0] m_rresp, m_rlast, m_rvalid, m_rready;

  axi_addr_router dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awln(s_awln), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arln(s_arln), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awln(m_awln), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arln(m_arln), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct {
    bit          is_read;
    logic [7:0]  id;
    logic [31:0] data;
    logic        resp;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else n_pass++;
  endfunction

  // Monitor: samples 3 ns after the falling edge, while inputs are stable
  // ahead of the next rising edge.
  task automatic pop_cmp(input bit is_read, input logic [7:0] id,
                         input logic [31:0] data, input logic resp, input logic last);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_resp: got %s id=%0h, want none",
               is_read ? "R" : "B", id);
      return;
    end
    e = exp_q.pop_front();
    check("resp_kind", 64'(is_read), 64'(e.is_read));
    check(is_read ? "r_id" : "b_id", 64'(id), 64'(e.id));
    check(is_read ? "r_resp" : "b_resp", 64'(resp), 64'(e.resp));
    if (is_read) begin
      check("r_data", 64'(data), 64'(e.data));
      check("r_last", 64'(last), 64'(e.last));
    end
  endtask

  always begin
    @(negedge clk);
    #3;
    if (rst_n && s_bvalid && s_bready) pop_cmp(1'b0, s_bid, 32'h0, s_bresp, 1'b1);
    if (rst_n && s_rvalid && s_rready) pop_cmp(1'b1, s_rid, s_rdata, s_rresp, s_rlast);
  end

  // Write transaction; slv = -1 means the address is expected to DECERR.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] id,
                          input int nbeats, input int slv, input bit same_cycle);
    logic [1:0]  exp_vec;
    logic [7:0]  seen_id;
    logic [31:0] d;
    exp_vec = (slv < 0) ? 2'b00 : 2'(2'b01 << slv);
    exp_q.push_back('{is_read: 1'b0, id: id, data: 32'h0, resp: (slv < 0), last: 1'b1});
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = addr; s_awid = id; s_awln = 8'(nbeats - 1);
    if (same_cycle) begin
      s_wvalid = 1'b1; s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF; s_wlast = (nbeats == 1);
    end
    #1;
    check("aw_route", 64'(m_awvalid), 64'(exp_vec));
    check("aw_ready", 64'(s_awready), 64'd1);
    check("w_blocked_in_idle", 64'(s_wready), 64'd0);
    check("w_valid_in_idle", 64'(m_wvalid), 64'd0);
    seen_id = (slv < 0) ? id : m_awid[slv*8 +: 8];
    @(negedge clk);
    s_awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = 32'hA5A5_A5A5 + 32'(b);
      s_wvalid = 1'b1; s_wdata = d; s_wstrb = 4'hF; s_wlast = (b == nbeats - 1);
      #1;
      check("w_route", 64'(m_wvalid), 64'(exp_vec));
      check("w_ready", 64'(s_wready), 64'd1);
      if (slv >= 0) check("w_data_bcast", 64'(m_wdata[slv*32 +: 32]), 64'(d));
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (slv >= 0) begin
      m_bvalid[slv] = 1'b1; m_bid[slv*8 +: 8] = seen_id; m_bresp[slv] = 1'b0;
    end
    #1;
    check("b_ready_route", 64'(m_bready), 64'(exp_vec));
    check("aw_valid_during_b", 64'(m_awvalid | m_wvalid), 64'd0);
    @(negedge clk);
    m_bvalid = '0;
    #1;
    check("b_done", 64'(s_bvalid), 64'd0);
    $display("WRITE addr=%h id=%h beats=%0d slave=%0d", addr, id, nbeats, slv);
  endtask

  // Read transaction; slv = -1 means DECERR. If abort_at >= 0, reset is
  // asserted while that beat is on the bus.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] id,
                         input int ln, input int slv, input int abort_at);
    logic [1:0]  exp_vec;
    logic [7:0]  seen_id;
    logic [31:0] d;
    exp_vec = (slv < 0) ? 2'b00 : 2'(2'b01 << slv);
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = addr; s_arid = id; s_arln = 8'(ln);
    #1;
    check("ar_route", 64'(m_arvalid), 64'(exp_vec));
    check("ar_ready", 64'(s_arready), 64'd1);
    seen_id = (slv < 0) ? id : m_arid[slv*8 +: 8];
    @(negedge clk);
    s_arvalid = 1'b0;
    for (int b = 0; b <= ln; b++) begin
      d = (slv < 0) ? 32'h0 : 32'hC0DE_0000 + 32'(b);
      if (slv >= 0) begin
        m_rvalid[slv] = 1'b1; m_rid[slv*8 +: 8] = seen_id;
        m_rdata[slv*32 +: 32] = d; m_rresp[slv] = 1'b0; m_rlast[slv] = (b == ln);
      end
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_s_valid_ready", 64'({s_rvalid, s_bvalid, s_arready, s_awready, s_wready}), 64'd0);
        check("rst_m_valid_ready", 64'({m_rready, m_arvalid, m_awvalid, m_wvalid, m_bready}), 64'd0);
        @(negedge clk);
        m_rvalid = '0; m_rlast = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("READ  addr=%h id=%h aborted by reset at beat %0d", addr, id, b + 1);
        return;
      end
      exp_q.push_back('{is_read: 1'b1, id: id, data: d, resp: (slv < 0), last: (b == ln)});
      #1;
      check("r_ready_route", 64'(m_rready), 64'(exp_vec));
      check("ar_valid_in_data", 64'(m_arvalid), 64'd0);
      @(negedge clk);
    end
    m_rvalid = '0; m_rlast = '0;
    #1;
    check("r_back_to_idle", 64'({s_arready, s_rvalid}), 64'b10);
    $display("READ  addr=%h id=%h beats=%0d slave=%0d", addr, id, ln + 1, slv);
  endtask

  initial begin
    rst_n = 1'b0;
    s_awid = '0; s_awaddr = 32'hFEED_0000; s_awln = '0; s_awsize = 2'd2; s_awburst = 2'd1;
    s_awvalid = 1'b1;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    s_arid = '0; s_araddr = 32'h1000_0000; s_arln = '0; s_arsize = 2'd2; s_arburst = 2'd1;
    s_arvalid = 1'b1; s_rready = 1'b1;
    m_awready = '1; m_wready = '1; m_arready = '1;
    m_bid = '0; m_bresp = '0; m_bvalid = '0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = '0; m_rvalid = '0;

    // Reset: requests present, yet every handshake signal stays low.
    repeat (2) @(negedge clk);
    #1;
    check("reset_m_valid", 64'({m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready}), 64'd0);
    check("reset_s_ready", 64'({s_awready, s_arready, s_wready, s_bvalid, s_rvalid}), 64'd0);
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    rst_n = 1'b1;

    // Write to slave 0 with AW and W in the same cycle.
    do_write(32'hFEED_0010, 8'h11, 1, 0, 1'b1);
    // Burst read from slave 1: four beats.
    do_read(32'h1000_0100, 8'h22, 3, 1, -1);
    // Read of an unmapped address: three error beats.
    do_read(32'h2000_0000, 8'h5A, 2, -1, -1);
    // Write to an unmapped address: two beats are sunk, then a DECERR response.
    do_write(32'h0000_0000, 8'h33, 2, -1, 1'b0);
    // Slave 1 write on the upper edge of its window.
    do_write(32'h1000_FFFC, 8'h44, 2, 1, 1'b0);
    // Reset during beat 2 of 4 of a slave 1 read, then a clean slave 0 read.
    do_read(32'h1000_0100, 8'h66, 3, 1, 1);
    @(negedge clk);
    do_read(32'hFEED_0040, 8'h77, 1, 0, -1);

    // Wait for the monitor to consume the remaining expectations.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
